// File: rtl/sfp_bank.sv
// sfp_bank: per-column multi-bank psum accumulators with an activation/drain FSM.
// Define SFP_BANK_SAT_EN for saturating accumulation; the default build wraps.
module sfp_bank #(
   parameter int col      = 8,
   parameter int psum_bw  = 16,
   parameter int bank_num = 4,
   parameter int leaky_sh = 3,
   parameter int bank_w   = $clog2(bank_num)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [psum_bw*col-1:0] in_psum,
   input  logic [col-1:0]         valid_in,
   input  logic [bank_w-1:0]      bank_sel,
   input  logic                   acc_clr,
   input  logic [1:0]             mode,
   input  logic                   drain_req,
   input  logic [bank_w-1:0]      drain_bank,
   output logic [psum_bw*col-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;

   state_t                    state_q, state_d;
   logic [bank_w-1:0]         dbank_q, dbank_d;
   logic signed [psum_bw-1:0] acc_q [bank_num][col];
   logic signed [psum_bw-1:0] acc_d [bank_num][col];
   logic [psum_bw*col-1:0]    out_data_q, out_data_d;
   logic                      out_valid_q, out_valid_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic                      collide;
   logic                      handshake;

   function automatic logic signed [psum_bw-1:0] add_acc(
      input logic signed [psum_bw-1:0] a,
      input logic signed [psum_bw-1:0] b
   );
`ifdef SFP_BANK_SAT_EN
      logic signed [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (s[psum_bw] != s[psum_bw-1])
         return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      return s[psum_bw-1:0];
`else
      return a + b;
`endif
   endfunction

   // Modes 01 and 11 are both ReLU, so bit 0 alone selects clamping outside leaky mode.
   function automatic logic signed [psum_bw-1:0] act(
      input logic signed [psum_bw-1:0] x,
      input logic [1:0]                m
   );
      logic signed [psum_bw-1:0] r;
      r = x;
      if (x[psum_bw-1]) begin
         if (m == 2'b10) r = x >>> leaky_sh;
         else if (m[0])  r = '0;
      end
      return r;
   endfunction

   // Any traffic aimed at the bank being drained is dropped and flagged.
   assign collide   = (state_q == LOAD || state_q == HOLD) && (bank_sel == dbank_q)
                      && (acc_clr || (|valid_in));
   assign handshake = (state_q == HOLD) && out_valid_q && out_ready;

   always_comb begin
      // NOTE: every comb output gets a default first, so no latch can be inferred.
      acc_d = acc_q;
      if (!collide) begin
         if (acc_clr) begin
            for (int k = 0; k < col; k++) acc_d[bank_sel][k] = '0;
         end else begin
            for (int k = 0; k < col; k++)
               if (valid_in[k])
                  acc_d[bank_sel][k] = add_acc(acc_q[bank_sel][k],
                                               $signed(in_psum[k*psum_bw +: psum_bw]));
         end
      end
      if (handshake)
         for (int k = 0; k < col; k++) acc_d[dbank_q][k] = '0;
   end

   // NOTE: sequential state uses non-blocking assignments only; comb logic uses blocking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dbank_q <= '0;
      end else begin
         state_q <= state_d;
         dbank_q <= dbank_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dbank_d = dbank_q;
      unique case (state_q)
         IDLE: if (drain_req) begin
            state_d = LOAD;
            dbank_d = drain_bank;
         end
         LOAD:    state_d = HOLD;
         HOLD:    if (handshake) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (state_q == LOAD) begin
         for (int k = 0; k < col; k++)
            out_data_d[k*psum_bw +: psum_bw] = act(acc_q[dbank_q][k], mode);
         out_valid_d = 1'b1;
      end
      if (handshake) out_valid_d = 1'b0;
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
      err_d  = err_q | collide;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the accumulator banks are reset too, since a reset must leave every bank at 0.
         for (int b = 0; b < bank_num; b++)
            for (int k = 0; k < col; k++) acc_q[b][k] <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_sfp_bank.sv
// Directed bench for sfp_bank: expected drain results are queued at request time
// and popped when out_valid is observed.
module tb_sfp_bank;
   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int NB  = 4;
   localparam int LSH = 3;
   localparam int BKW = 2;
   localparam int W   = COL * BW;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   in_psum;
   logic [COL-1:0] valid_in;
   logic [BKW-1:0] bank_sel;
   logic           acc_clr;
   logic [1:0]     mode;
   logic           drain_req;
   logic [BKW-1:0] drain_bank;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic           busy;
   logic           done;
   logic           err;

   logic [W-1:0] sb [$];
   int n_tests = 0;
   int n_fail  = 0;

   sfp_bank #(.col(COL), .psum_bw(BW), .bank_num(NB), .leaky_sh(LSH), .bank_w(BKW)) dut (
      .clk(clk), .reset(reset), .in_psum(in_psum), .valid_in(valid_in),
      .bank_sel(bank_sel), .acc_clr(acc_clr), .mode(mode), .drain_req(drain_req),
      .drain_bank(drain_bank), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] rep(input logic [BW-1:0] v);
      return {COL{v}};
   endfunction

   function automatic logic [W-1:0] col0(input logic [BW-1:0] v);
      return {{(W-BW){1'b0}}, v};
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      valid_in  = '0;
      acc_clr   = 1'b0;
      drain_req = 1'b0;
   endtask

   task automatic acc(input logic [BKW-1:0] b, input logic [COL-1:0] v, input logic [BW-1:0] val);
      tick();
      bank_sel = b;
      valid_in = v;
      in_psum  = rep(val);
   endtask

   task automatic clr(input logic [BKW-1:0] b, input logic with_valid);
      tick();
      bank_sel = b;
      acc_clr  = 1'b1;
      valid_in = with_valid ? '1 : '0;
      in_psum  = rep(16'd99);
   endtask

   // Drain with drain_req on cycle t; stall = cycles out_ready stays low after out_valid rises.
   task automatic drain(input logic [BKW-1:0] b, input logic [1:0] md, input int stall,
                        input logic coll, input logic rereq, input logic [W-1:0] exp,
                        input string tag);
      logic [W-1:0] exp_q;
      sb.push_back(exp);
      tick();
      drain_req  = 1'b1;
      drain_bank = b;
      mode       = md;
      out_ready  = (stall == 0);
      tick();
      if (coll) begin
         bank_sel = 2'd3;
         valid_in = '1;
         in_psum  = rep(16'd7);
      end
      @(negedge clk);
      check({tag, ":busy_t1"}, W'(busy), W'(1));
      check({tag, ":valid_t1"}, W'(out_valid), W'(0));
      tick();
      mode = md ^ 2'b01;
      if (coll) begin
         bank_sel = 2'd2;
         valid_in = '1;
         in_psum  = rep(16'd9);
      end
      if (rereq) begin
         drain_req  = 1'b1;
         drain_bank = b ^ 2'd1;
      end
      @(negedge clk);
      exp_q = sb.pop_front();
      check({tag, ":valid_t2"}, W'(out_valid), W'(1));
      check({tag, ":data"}, out_data, exp_q);
      for (int i = 0; i < stall; i++) begin
         tick();
         if (i == stall - 1) out_ready = 1'b1;
         @(negedge clk);
         check({tag, ":stall_valid"}, W'(out_valid), W'(1));
         check({tag, ":stall_data"}, out_data, exp_q);
         check({tag, ":stall_busy"}, W'(busy), W'(1));
         check({tag, ":stall_done"}, W'(done), W'(0));
      end
      tick();
      @(negedge clk);
      check({tag, ":done"}, W'(done), W'(1));
      check({tag, ":valid_done"}, W'(out_valid), W'(0));
      check({tag, ":busy_done"}, W'(busy), W'(1));
      tick();
      @(negedge clk);
      check({tag, ":done_pulse"}, W'(done), W'(0));
      check({tag, ":idle_busy"}, W'(busy), W'(0));
   endtask

   initial begin
      reset      = 1'b1;
      in_psum    = '0;
      valid_in   = '0;
      bank_sel   = '0;
      acc_clr    = 1'b0;
      mode       = 2'b00;
      drain_req  = 1'b0;
      drain_bank = '0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst:out_data", out_data, '0);
      check("rst:out_valid", W'(out_valid), W'(0));
      check("rst:busy", W'(busy), W'(0));
      check("rst:done", W'(done), W'(0));
      check("rst:err", W'(err), W'(0));
      reset = 1'b0;

      // Basic accumulation, ReLU drain
      acc(2'd0, '1, 16'd100);
      acc(2'd0, '1, 16'd200);
      acc(2'd0, '1, -16'sd50);
      drain(2'd0, 2'b01, 0, 1'b0, 1'b0, rep(16'd250), "basic");

      // Activation modes on column 0 of bank 1
      acc(2'd1, 8'h01, -16'sd64);
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, col0(16'hFFC0), "bypass");
      acc(2'd1, 8'h01, -16'sd64);
      drain(2'd1, 2'b01, 0, 1'b0, 1'b0, col0(16'h0000), "relu");
      acc(2'd1, 8'h01, -16'sd64);
      drain(2'd1, 2'b10, 0, 1'b0, 1'b0, col0(16'hFFF8), "leaky");
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, '0, "redrain");
      acc(2'd1, 8'h01, 16'd40);
      drain(2'd1, 2'b10, 0, 1'b0, 1'b0, col0(16'd40), "leaky_pos");
      acc(2'd1, 8'h01, -16'sd64);
      drain(2'd1, 2'b11, 0, 1'b0, 1'b0, col0(16'h0000), "relu11");

      // Explicit clear, and clear winning over same-cycle accumulation
      acc(2'd1, '1, 16'd11);
      clr(2'd1, 1'b0);
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, '0, "clr");
      acc(2'd1, '1, 16'd11);
      clr(2'd1, 1'b1);
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, '0, "clr_prio");

      // Backpressure: five cycles of out_ready low, then bank cleared
      acc(2'd0, '1, 16'd300);
      drain(2'd0, 2'b01, 5, 1'b0, 1'b0, rep(16'd300), "bp");
      drain(2'd0, 2'b00, 0, 1'b0, 1'b0, '0, "bp_after");
      @(negedge clk);
      check("pre_coll:err", W'(err), W'(0));

      // Interleave and collision, with an ignored request mid-drain
      acc(2'd2, '1, 16'd21);
      drain(2'd2, 2'b00, 0, 1'b1, 1'b1, rep(16'd21), "coll");
      @(negedge clk);
      check("coll:err", W'(err), W'(1));
      check("coll:no_queued_req", W'(busy), W'(0));
      drain(2'd3, 2'b00, 0, 1'b0, 1'b0, rep(16'd7), "bank3");
      drain(2'd2, 2'b00, 0, 1'b0, 1'b0, '0, "bank2_after");

      // Overflow, both directions
      acc(2'd0, 8'h01, 16'h7FFF);
      acc(2'd0, 8'h01, 16'd1);
`ifdef SFP_BANK_SAT_EN
      drain(2'd0, 2'b00, 0, 1'b0, 1'b0, col0(16'h7FFF), "ovf_pos");
`else
      drain(2'd0, 2'b00, 0, 1'b0, 1'b0, col0(16'h8000), "ovf_pos");
`endif
      acc(2'd1, 8'h01, 16'h8000);
      acc(2'd1, 8'h01, 16'hFFFF);
`ifdef SFP_BANK_SAT_EN
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, col0(16'h8000), "ovf_neg");
`else
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, col0(16'h7FFF), "ovf_neg");
`endif

      // Reset during HOLD
      acc(2'd1, '1, 16'd55);
      acc(2'd0, '1, 16'd66);
      tick();
      drain_req  = 1'b1;
      drain_bank = 2'd1;
      mode       = 2'b00;
      out_ready  = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst_mid:pre_valid", W'(out_valid), W'(1));
      check("rst_mid:pre_data", out_data, rep(16'd55));
      #1 reset = 1'b1;
      #1;
      check("rst_mid:out_valid", W'(out_valid), W'(0));
      check("rst_mid:busy", W'(busy), W'(0));
      check("rst_mid:err", W'(err), W'(0));
      check("rst_mid:out_data", out_data, '0);
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      drain(2'd1, 2'b00, 0, 1'b0, 1'b0, '0, "rst_b1");
      drain(2'd0, 2'b00, 0, 1'b0, 1'b0, '0, "rst_b0");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sfp_bank.md
# sfp_bank

Multi-bank post-processing unit between the last MAC-array row and the output FIFO. Each column accumulates incoming partial sums into one of `bank_num` independent accumulator banks, so several output channels or tiles can be accumulated in an interleaved order. A drain state machine applies a selectable activation to one bank and hands it to the output FIFO with a valid/ready handshake. The drained bank is then cleared automatically.

## Interface
- `col`, 8: number of columns/channels.
- `psum_bw`, 16: width of the incoming psum and the accumulator, per column, signed.
- `bank_num`, 4: accumulator banks per column; a power of 2, at least 2.
- `leaky_sh`, 3: arithmetic right shift applied to negative values in leaky mode.
- `bank_w`, derived as clog2(`bank_num`): width of the bank index.

Ports (all registered outputs):
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `in_psum` in `psum_bw*col`: column k occupies bits [(k+1)*psum_bw-1 : k*psum_bw].
- `valid_in` in `col`: per-column accumulate enable.
- `bank_sel` in `bank_w`: target bank for `valid_in` and `acc_clr`.
- `acc_clr` in 1: clears all columns of `bank_sel`.
- `mode` in 2: activation select. 00 = bypass, 01 = ReLU, 10 = leaky, 11 = ReLU.
- `drain_req` in 1: request to drain `drain_bank`.
- `drain_bank` in `bank_w`: bank to drain.
- `out_data` out `psum_bw*col`: activated bank contents. Reset value 0.
- `out_valid` out 1: `out_data` is valid, acting as the FIFO write enable. Reset value 0.
- `out_ready` in 1: FIFO can accept data.
- `busy` out 1: high in any state other than IDLE. Reset value 0.
- `done` out 1: one-cycle pulse after a completed drain. Reset value 0.
- `err` out 1: sticky collision flag. Reset value 0. Cleared only by `reset`.

## Operation
Accumulation is per column k, every cycle:
- If `acc_clr` is high, all columns of `acc[bank_sel]` become 0. Clear has priority over accumulation in the same cycle.
- Otherwise, if `valid_in[k]` is high, `acc[bank_sel][k]` becomes `acc + in_psum_k`.
- Arithmetic is signed two's complement on `psum_bw` bits. Overflow handling is set under Configuration.
- The activation is not applied during accumulation; a bank holds raw signed sums.

Activation is applied per column at drain time:
- Bypass: the value is passed unchanged.
- ReLU: values below 0 become 0.
- Leaky: values below 0 become x>>>`leaky_sh`; values of 0 or above are unchanged.

The drain FSM has four states:
- IDLE: if `drain_req` is high, latch `drain_bank` as `dbank` and go to LOAD.
- LOAD: `out_data` captures act(`acc[dbank]`) for all columns and `out_valid` goes to 1. Go to HOLD.
- HOLD: `out_data` and `out_valid` hold stable. When `out_valid` and `out_ready` are both high, `acc[dbank]` is cleared, `out_valid` goes to 0, and the FSM goes to DONE.
- DONE: `done` is 1 for this cycle only. Go to IDLE.

Collisions and boundary cases:
- `valid_in` or `acc_clr` targeting `dbank` while in LOAD or HOLD is dropped, and `err` is set to 1.
- Accumulation into any other bank proceeds normally during a drain.
- `drain_req` outside IDLE is ignored; no request is queued.
- `mode` is sampled in the LOAD cycle only. Changing it during HOLD does not alter `out_data`.
- `reset` mid-drain returns the FSM to IDLE and zeroes all banks and all outputs.

## Timing
- Accumulation latency is 1: the sum is visible in the accumulator at the edge after `valid_in`.
- A bank fed on cycle t and drained with `drain_req` on t+1 includes cycle t's data.
- Drain latency: `drain_req` on cycle t gives `out_valid` high from t+2.
- With `out_ready` held high, the handshake completes at the t+2 edge and `done` is high on t+3.
- The minimum drain-to-drain interval is 4 cycles.
- `busy` is high from t+1 until DONE exits.

## Configuration
- `SFP_BANK_SAT_EN` defined: accumulation saturates. Positive overflow gives 2^(psum_bw-1)-1; negative overflow gives -2^(psum_bw-1).
- `SFP_BANK_SAT_EN` undefined: accumulation wraps modulo 2^psum_bw.
- The macro does not change any ports or timing.

## Test plan
- Basic accumulation: psum_bw=16, bank 0, all columns. Feed +100, +200 and -50 on three cycles, then drain with mode=01 and `out_ready`=1. Required: every column of `out_data` = 250 and `done` on t+3.
- Activation modes: bank 1 col 0 accumulates -64.
  - Mode 00 gives -64.
  - Mode 01 gives 0.
  - Mode 10 with `leaky_sh`=3 gives -8.
  - A re-drain after clear gives 0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises. Required: `out_data` stable, `busy`=1, and the bank is not cleared until the handshake.
- Interleaving and collision: during a drain of bank 2, accumulate +7 into bank 3 and +9 into bank 2. Required: bank 3 = 7, bank 2 drains to its pre-drain value and then reads 0, and `err`=1.
- Overflow: accumulate 32767 then +1.
  - With `SFP_BANK_SAT_EN`: bypass drain gives 32767.
  - Without it: bypass drain gives -32768.
- Reset mid-drain: assert `reset` during HOLD. Required: `out_valid`=0, `busy`=0, `err`=0, and a subsequent drain of any bank reads 0.
